scaled_raster_reader: RTL and testbench

SCALED_RASTER_READER -- requirements
Module: scaled_raster_reader

---
 rtl/video_pkg.sv | 50 +++++
 rtl/pipe_delay.sv | 29 ++
 rtl/scaled_raster_reader.sv | 230 +++++++++++++++++++++++
 tb/tb_scaled_raster_reader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Shared raster types: timing/scale configuration, FSM states and the Q1.12
// phase-accumulator step used by both scaling axes.
package video_pkg;

   localparam int CFG_CNT_W  = 12;
   localparam int CFG_ADDR_W = 14;
   localparam int STEP_W     = 13;

   localparam logic [STEP_W:0] PHASE_ONE = 14'd4096;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   typedef struct packed {
      logic [CFG_CNT_W-1:0]  h_total;
      logic [CFG_CNT_W-1:0]  h_active;
      logic [CFG_CNT_W-1:0]  h_sync_start;
      logic [CFG_CNT_W-1:0]  h_sync_width;
      logic                  h_sync_pol;
      logic [CFG_CNT_W-1:0]  v_total;
      logic [CFG_CNT_W-1:0]  v_active;
      logic [CFG_CNT_W-1:0]  v_sync_start;
      logic [CFG_CNT_W-1:0]  v_sync_width;
      logic                  v_sync_pol;
      logic [CFG_CNT_W-1:0]  src_width;
      logic [CFG_CNT_W-1:0]  src_height;
      logic [CFG_ADDR_W-1:0] line_stride;
      logic [STEP_W-1:0]     h_step;
      logic [STEP_W-1:0]     v_step;
   } raster_cfg_t;

   typedef struct packed {
      logic              carry;
      logic [STEP_W-1:0] acc;
   } phase_t;

   // One accumulator step: carry means "advance one source pixel/line".
   function automatic phase_t phase_advance(input logic [STEP_W-1:0] acc,
                                            input logic [STEP_W-1:0] step);
      logic [STEP_W:0] sum;
      phase_t          res;
      sum       = {1'b0, acc} + {1'b0, step};
      res.carry = (sum >= PHASE_ONE);
      res.acc   = res.carry ? STEP_W'(sum - PHASE_ONE) : STEP_W'(sum);
      return res;
   endfunction

endpackage

// File: rtl/pipe_delay.sv
// Fixed-length shift register used to align control/sync bits with the
// framebuffer read pipeline.
module pipe_delay #(
   parameter int               CYCLES  = 1,
   parameter int               WIDTH   = 1,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH-1:0] stage_q [CYCLES];

   // NOTE: this array is a delay line, not storage, so every stage is reset;
   // sequential state is always written with non-blocking assignments.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < CYCLES; i++) stage_q[i] <= RST_VAL;
      end else begin
         stage_q[0] <= d_i;
         for (int i = 1; i < CYCLES; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_o = stage_q[CYCLES-1];

endmodule

// File: rtl/scaled_raster_reader.sv
// Raster timing generator that scales a framebuffer image onto the output
// timing. Optional build macro RASTER_SCANLINE_EN dims odd output lines.
module scaled_raster_reader
   import video_pkg::*;
#(
   parameter int CNT_W  = 12,
   parameter int ADDR_W = 14,
   parameter int PIX_W  = 24,
   parameter int RD_LAT = 2
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  raster_cfg_t       cfg,
   output logic [ADDR_W-1:0] rdaddr,
   input  logic [PIX_W-1:0]  rddata,
`ifdef RASTER_SCANLINE_EN
   input  logic [7:0]        scanline_level,
`endif
   output logic [PIX_W-1:0]  video_out,
   output logic              de,
   output logic              hsync,
   output logic              vsync,
   output logic              frame_start,
   output logic              running
);

   localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

   state_e            state_q;
   raster_cfg_t       shadow_q;
   logic [CNT_W-1:0]  x_q, y_q, src_x_q, src_y_q;
   logic [STEP_W-1:0] acc_x_q, acc_y_q;
   logic [ADDR_W-1:0] row_base_q, rdaddr_q;

   logic [CNT_W-1:0]  h_total_s, h_active_s, v_total_s, v_active_s, src_w_s, src_h_s;
   logic [CNT_W:0]    h_sync_lo, h_sync_hi, v_sync_lo, v_sync_hi;
   logic [ADDR_W-1:0] stride_s;
   logic              run_c, x_last, y_last, y_active, pix_active;
   logic              h_in_sync, v_in_sync, hs_c, vs_c, fs_c;
   logic              src_x_room, src_y_room;
   phase_t            ph_x, ph_y;

   assign h_total_s  = CNT_W'(shadow_q.h_total);
   assign h_active_s = CNT_W'(shadow_q.h_active);
   assign v_total_s  = CNT_W'(shadow_q.v_total);
   assign v_active_s = CNT_W'(shadow_q.v_active);
   assign src_w_s    = CNT_W'(shadow_q.src_width);
   assign src_h_s    = CNT_W'(shadow_q.src_height);
   assign stride_s   = ADDR_W'(shadow_q.line_stride);

   assign run_c      = (state_q == ST_RUN);
   assign x_last     = (x_q == h_total_s - ONE_C);
   assign y_last     = (y_q == v_total_s - ONE_C);
   assign y_active   = (y_q < v_active_s);
   assign pix_active = run_c && (x_q < h_active_s) && y_active;

   // Sync windows compared one bit wider so start+width cannot wrap.
   assign h_sync_lo = (CNT_W+1)'(shadow_q.h_sync_start);
   assign h_sync_hi = h_sync_lo + (CNT_W+1)'(shadow_q.h_sync_width);
   assign v_sync_lo = (CNT_W+1)'(shadow_q.v_sync_start);
   assign v_sync_hi = v_sync_lo + (CNT_W+1)'(shadow_q.v_sync_width);
   assign h_in_sync = ({1'b0, x_q} >= h_sync_lo) && ({1'b0, x_q} < h_sync_hi);
   assign v_in_sync = ({1'b0, y_q} >= v_sync_lo) && ({1'b0, y_q} < v_sync_hi);

   assign hs_c = (run_c && h_in_sync) ? shadow_q.h_sync_pol : ~shadow_q.h_sync_pol;
   assign vs_c = (run_c && v_in_sync) ? shadow_q.v_sync_pol : ~shadow_q.v_sync_pol;
   assign fs_c = run_c && (x_q == '0) && (y_q == '0);

   assign ph_x       = phase_advance(acc_x_q, shadow_q.h_step);
   assign ph_y       = phase_advance(acc_y_q, shadow_q.v_step);
   assign src_x_room = (src_x_q < src_w_s - ONE_C);
   assign src_y_room = (src_y_q < src_h_s - ONE_C);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         shadow_q   <= '0;
         x_q        <= '0;
         y_q        <= '0;
         acc_x_q    <= '0;
         acc_y_q    <= '0;
         src_x_q    <= '0;
         src_y_q    <= '0;
         row_base_q <= '0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (start) begin
                  state_q    <= ST_RUN;
                  shadow_q   <= cfg;
                  x_q        <= '0;
                  y_q        <= '0;
                  acc_x_q    <= '0;
                  acc_y_q    <= '0;
                  src_x_q    <= '0;
                  src_y_q    <= '0;
                  row_base_q <= '0;
               end
            end
            ST_RUN: begin
               if (x_last) begin
                  x_q     <= '0;
                  acc_x_q <= '0;
                  src_x_q <= '0;
                  if (y_last) begin
                     // Frame boundary: the only point a new config takes hold.
                     y_q        <= '0;
                     shadow_q   <= cfg;
                     acc_y_q    <= '0;
                     src_y_q    <= '0;
                     row_base_q <= '0;
                  end else begin
                     y_q <= y_q + ONE_C;
                     if (y_active) begin
                        acc_y_q <= ph_y.acc;
                        if (ph_y.carry && src_y_room) begin
                           src_y_q    <= src_y_q + ONE_C;
                           row_base_q <= row_base_q + stride_s;
                        end
                     end
                  end
               end else begin
                  x_q <= x_q + ONE_C;
                  if (pix_active) begin
                     acc_x_q <= ph_x.acc;
                     if (ph_x.carry && src_x_room) src_x_q <= src_x_q + ONE_C;
                  end
               end
            end
         endcase
      end
   end

`ifdef RASTER_SCANLINE_EN
   localparam int             SIG_W   = 5;
   localparam logic [SIG_W-1:0] SIG_RST = 5'b00110;
   logic [SIG_W-1:0] sig_c;
   assign sig_c = {y_q[0], fs_c, vs_c, hs_c, pix_active};
`else
   localparam int             SIG_W   = 4;
   localparam logic [SIG_W-1:0] SIG_RST = 4'b0110;
   logic [SIG_W-1:0] sig_c;
   assign sig_c = {fs_c, vs_c, hs_c, pix_active};
`endif

   logic [SIG_W-1:0] sig_dly;

   // Control bits wait for the address register plus the memory latency.
   pipe_delay #(
      .CYCLES  (RD_LAT + 1),
      .WIDTH   (SIG_W),
      .RST_VAL (SIG_RST)
   ) u_sig_dly (
      .clock (clock),
      .reset (reset),
      .d_i   (sig_c),
      .q_o   (sig_dly)
   );

   logic [PIX_W-1:0] video_q;
   logic             de_q, hsync_q, vsync_q, fs_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rdaddr_q <= '0;
         video_q  <= '0;
         de_q     <= 1'b0;
         hsync_q  <= 1'b1;
         vsync_q  <= 1'b1;
         fs_q     <= 1'b0;
      end else begin
         rdaddr_q <= pix_active ? (row_base_q + ADDR_W'(src_x_q)) : '0;
         video_q  <= sig_dly[0] ? rddata : '0;
         de_q     <= sig_dly[0];
         hsync_q  <= sig_dly[1];
         vsync_q  <= sig_dly[2];
         fs_q     <= sig_dly[3];
      end
   end

   assign rdaddr  = rdaddr_q;
   assign running = run_c;

`ifdef RASTER_SCANLINE_EN
   logic             odd_q, de2_q, hsync2_q, vsync2_q, fs2_q;
   logic [PIX_W-1:0] dim_c, video2_q;

   // NOTE: dim_c gets a full default before the conditional so no latch forms.
   always_comb begin
      dim_c = video_q;
      if (odd_q) begin
         for (int b = 0; b < PIX_W / 8; b++) begin
            dim_c[b*8 +: 8] = 8'((16'(video_q[b*8 +: 8]) * 16'(scanline_level)) >> 8);
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         odd_q    <= 1'b0;
         video2_q <= '0;
         de2_q    <= 1'b0;
         hsync2_q <= 1'b1;
         vsync2_q <= 1'b1;
         fs2_q    <= 1'b0;
      end else begin
         odd_q    <= sig_dly[4];
         video2_q <= dim_c;
         de2_q    <= de_q;
         hsync2_q <= hsync_q;
         vsync2_q <= vsync_q;
         fs2_q    <= fs_q;
      end
   end

   assign video_out   = video2_q;
   assign de          = de2_q;
   assign hsync       = hsync2_q;
   assign vsync       = vsync2_q;
   assign frame_start = fs2_q;
`else
   assign video_out   = video_q;
   assign de          = de_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_start = fs_q;
`endif

endmodule

// File: tb/tb_scaled_raster_reader.sv
// Directed bench for scaled_raster_reader (default build): 10x5 raster,
// 6x3 active area, synchronous framebuffer model with RD_LAT latency.
module tb_scaled_raster_reader;
   import video_pkg::*;

   localparam int RD_LAT   = 2;
   localparam int L        = RD_LAT + 2;
   localparam int H_TOTAL  = 10;
   localparam int V_TOTAL  = 5;
   localparam int V_ACTIVE = 3;
   localparam int STRIDE   = 6;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   raster_cfg_t cfg;
   logic [13:0] rdaddr;
   logic [23:0] rddata, video_out;
   logic        de, hsync, vsync, frame_start, running;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_sx[H_TOTAL];
   int exp_sy[V_TOTAL];
   int hact0, hact1;

   logic [13:0] rd_pipe [RD_LAT];

   scaled_raster_reader #(
      .CNT_W  (12),
      .ADDR_W (14),
      .PIX_W  (24),
      .RD_LAT (RD_LAT)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .cfg         (cfg),
      .rdaddr      (rdaddr),
      .rddata      (rddata),
      .video_out   (video_out),
      .de          (de),
      .hsync       (hsync),
      .vsync       (vsync),
      .frame_start (frame_start),
      .running     (running)
   );

   always #5 clock = ~clock;

   function automatic logic [23:0] mem_word(input logic [13:0] a);
      return {10'h2A5, a};
   endfunction

   always @(posedge clock) begin
      rd_pipe[0] <= rdaddr;
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign rddata = mem_word(rd_pipe[RD_LAT-1]);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Expected outputs for counter index n (cycles since the start edge).
   function automatic void expect_at(input int n, output logic act, output logic [13:0] addr,
                                     output logic hs, output logic vs, output logic fs);
      int x, y, hact;
      x    = n % H_TOTAL;
      y    = (n / H_TOTAL) % V_TOTAL;
      hact = (n < H_TOTAL * V_TOTAL) ? hact0 : hact1;
      act  = (x < hact) && (y < V_ACTIVE);
      addr = act ? 14'(exp_sy[y] * STRIDE + exp_sx[x]) : 14'd0;
      hs   = !(x == 7 || x == 8);
      vs   = (y == 3);
      fs   = (x == 0) && (y == 0);
   endfunction

   function automatic raster_cfg_t base_cfg();
      raster_cfg_t c;
      c              = '0;
      c.h_total      = 12'd10;
      c.h_active     = 12'd6;
      c.h_sync_start = 12'd7;
      c.h_sync_width = 12'd2;
      c.h_sync_pol   = 1'b0;
      c.v_total      = 12'd5;
      c.v_active     = 12'd3;
      c.v_sync_start = 12'd3;
      c.v_sync_width = 12'd1;
      c.v_sync_pol   = 1'b1;
      c.src_width    = 12'd16;
      c.src_height   = 12'd16;
      c.line_stride  = 14'd6;
      c.h_step       = 13'd4096;
      c.v_step       = 13'd4096;
      return c;
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      start = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic pulse_start();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   task automatic check_idle(input string tag);
      check({tag, " rdaddr"},      32'(rdaddr),      32'd0);
      check({tag, " video_out"},   32'(video_out),   32'd0);
      check({tag, " de"},          32'(de),          32'd0);
      check({tag, " frame_start"}, 32'(frame_start), 32'd0);
      check({tag, " running"},     32'(running),     32'd0);
      check({tag, " hsync"},       32'(hsync),       32'd1);
      check({tag, " vsync"},       32'(vsync),       32'd1);
   endtask

   // Must be entered right after the start edge: first negedge is k=0.
   task automatic scan(input int ncyc);
      logic        act, hs, vs, fs;
      logic [13:0] addr;
      int          n;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clock);
         if (k == 0) check("running", 32'(running), 32'd1);
         if (k >= 1) begin
            n = k - 1;
            expect_at(n, act, addr, hs, vs, fs);
            check($sformatf("rdaddr n=%0d", n), 32'(rdaddr), 32'(addr));
         end
         if (k >= L) begin
            n = k - L;
            expect_at(n, act, addr, hs, vs, fs);
            check($sformatf("de n=%0d", n),          32'(de),          32'(act));
            check($sformatf("hsync n=%0d", n),       32'(hsync),       32'(hs));
            check($sformatf("vsync n=%0d", n),       32'(vsync),       32'(vs));
            check($sformatf("frame_start n=%0d", n), 32'(frame_start), 32'(fs));
            check($sformatf("video_out n=%0d", n),   32'(video_out),
                  act ? 32'(mem_word(addr)) : 32'd0);
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      cfg   = base_cfg();
      hact0 = 6;
      hact1 = 6;
      exp_sx = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
      exp_sy = '{0, 1, 2, 3, 4};

      // Reset values, and IDLE holding them without a start.
      do_reset();
      check_idle("reset");
      @(negedge clock);
      check_idle("idle");

      // Unity scale: addresses 0..5, 6..11, 12..17; two frames.
      pulse_start();
      scan(2 * H_TOTAL * V_TOTAL + L);

      // Half-rate both axes: each source pixel and line doubled.
      do_reset();
      cfg        = base_cfg();
      cfg.h_step = 13'd2048;
      cfg.v_step = 13'd2048;
      exp_sx     = '{0, 0, 1, 1, 2, 2, 0, 0, 0, 0};
      exp_sy     = '{0, 0, 1, 0, 0};
      pulse_start();
      scan(H_TOTAL * V_TOTAL + L);

      // 2x2 source: src_x and src_y saturate instead of wrapping.
      do_reset();
      cfg            = base_cfg();
      cfg.src_width  = 12'd2;
      cfg.src_height = 12'd2;
      exp_sx         = '{0, 1, 1, 1, 1, 1, 0, 0, 0, 0};
      exp_sy         = '{0, 1, 1, 0, 0};
      pulse_start();
      scan(H_TOTAL * V_TOTAL + L);

      // Zero horizontal step repeats one column; 1.5 vertical step.
      do_reset();
      cfg        = base_cfg();
      cfg.h_step = 13'd0;
      cfg.v_step = 13'd6144;
      exp_sx     = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
      exp_sy     = '{0, 1, 2, 0, 0};
      pulse_start();
      scan(H_TOTAL * V_TOTAL + L);

      // Mid-frame h_active change lands at the next frame; start in RUN ignored.
      do_reset();
      cfg    = base_cfg();
      exp_sx = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
      exp_sy = '{0, 1, 2, 3, 4};
      hact0  = 6;
      hact1  = 4;
      pulse_start();
      fork
         scan(2 * H_TOTAL * V_TOTAL + L);
         begin
            repeat (21) @(negedge clock);
            cfg.h_active = 12'd4;
            start        = 1'b1;
            @(negedge clock);
            start        = 1'b0;
         end
      join

      // Reset at x=3,y=1 aborts at once; the next start begins at (0,0).
      do_reset();
      cfg   = base_cfg();
      hact1 = 6;
      pulse_start();
      repeat (14) @(negedge clock);
      reset = 1'b1;
      #1;
      check_idle("abort");
      @(negedge clock);
      reset = 1'b0;
      pulse_start();
      scan(H_TOTAL * V_TOTAL + L);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
